// File: rtl/sample_fifo_pkg.sv
// Shared sizing constants and helpers for the host-to-modulator sample FIFO.
// The host receiver and the modulator top level import the same constants.
package sample_fifo_pkg;

  localparam int SAMPLE_WIDTH      = 8;
  localparam int SAMPLE_FIFO_DEPTH = 64;
  localparam int SAMPLE_FIFO_AF    = 48;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e classify_op(input logic do_wr, input logic do_rd);
    fifo_op_e op;
    case ({do_rd, do_wr})
      2'b01:   op = OP_PUSH;
      2'b10:   op = OP_POP;
      2'b11:   op = OP_BOTH;
      default: op = OP_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/sample_fifo_mem.sv
// Dual-port storage for sample_fifo: one synchronous write port, one
// asynchronous read port so the head word is visible without a read cycle.
module fifo_mem_dp #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  // Contents are intentionally not reset so this maps onto distributed RAM.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sample_fifo.sv
// Show-ahead byte FIFO between the host receiver and the PAM modulator,
// with occupancy, almost-full and sticky overflow/underflow reporting.
module sample_fifo
  import sample_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = SAMPLE_WIDTH,
  parameter int DEPTH        = SAMPLE_FIFO_DEPTH,
  parameter int AF_THRESHOLD = SAMPLE_FIFO_AF,
  localparam int LEVEL_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   write,
  output logic                   full,
  output logic                   almost_full,
  output logic [DATA_WIDTH-1:0]  sample,
  input  logic                   read,
  output logic                   empty,
  output logic [LEVEL_WIDTH-1:0] level,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [LEVEL_WIDTH-1:0] DEPTH_LVL = LEVEL_WIDTH'(DEPTH);
  localparam logic [LEVEL_WIDTH-1:0] AF_LVL    = LEVEL_WIDTH'(AF_THRESHOLD);
  localparam logic [LEVEL_WIDTH-1:0] ONE_LVL   = LEVEL_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0]  ONE_PTR   = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0]  wr_ptr;
  logic [ADDR_WIDTH-1:0]  rd_ptr;
  logic [ADDR_WIDTH-1:0]  wr_ptr_next;
  logic [ADDR_WIDTH-1:0]  rd_ptr_next;
  logic [LEVEL_WIDTH-1:0] level_next;
  logic                   overflow_next;
  logic                   underflow_next;
  logic                   do_rd;
  logic                   do_wr;
  logic                   mem_we;
  fifo_op_e               op;

  // A pop frees a slot in the same cycle, so a full FIFO still takes a write
  // when the modulator drains concurrently.
  assign do_rd  = read & ~empty;
  assign do_wr  = write & (~full | do_rd);
  assign op     = classify_op(do_wr, do_rd);
  assign mem_we = do_wr & ~flush;

  always_comb begin
    wr_ptr_next    = wr_ptr;
    rd_ptr_next    = rd_ptr;
    level_next     = level;
    overflow_next  = overflow | (write & ~do_wr);
    underflow_next = underflow | (read & empty);

    case (op)
      OP_PUSH: begin
        wr_ptr_next = wr_ptr + ONE_PTR;
        level_next  = level + ONE_LVL;
      end
      OP_POP: begin
        rd_ptr_next = rd_ptr + ONE_PTR;
        level_next  = level - ONE_LVL;
      end
      OP_BOTH: begin
        wr_ptr_next = wr_ptr + ONE_PTR;
        rd_ptr_next = rd_ptr + ONE_PTR;
      end
      default: begin
      end
    endcase

    if (flush) begin
      wr_ptr_next    = '0;
      rd_ptr_next    = '0;
      level_next     = '0;
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end
  end

  // Flags are registered from the next occupancy so they line up with level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_next;
      rd_ptr      <= rd_ptr_next;
      level       <= level_next;
      empty       <= (level_next == '0);
      full        <= (level_next == DEPTH_LVL);
      almost_full <= (level_next >= AF_LVL);
      overflow    <= overflow_next;
      underflow   <= underflow_next;
    end
  end

  fifo_mem_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (sample)
  );

endmodule

// File: tb/tb_sample_fifo.sv
// Self-checking bench for sample_fifo: directed scenarios plus a randomized
// run, all checked against a queue-based model of the FIFO rules.
module tb_sample_fifo;
  import sample_fifo_pkg::*;

  localparam int DW = SAMPLE_WIDTH;
  localparam int DP = SAMPLE_FIFO_DEPTH;
  localparam int AF = SAMPLE_FIFO_AF;
  localparam int LW = $clog2(DP + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          write = 1'b0;
  logic          read = 1'b0;
  logic          full;
  logic          almost_full;
  logic [DW-1:0] sample;
  logic          empty;
  logic [LW-1:0] level;
  logic          overflow;
  logic          underflow;

  int total = 0;
  int bad   = 0;

  // Reference model: contents as a queue plus the two sticky flags.
  logic [DW-1:0] model_q[$];
  logic          model_ovf = 1'b0;
  logic          model_unf = 1'b0;

  sample_fifo dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wr_data     (wr_data),
    .write       (write),
    .full        (full),
    .almost_full (almost_full),
    .sample      (sample),
    .read        (read),
    .empty       (empty),
    .level       (level),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, take the edge, and apply the same rules to the model.
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
    bit pop;
    bit push;
    write   = w;
    wr_data = d;
    read    = r;
    flush   = f;
    @(posedge clk);
    #1;
    if (f) begin
      model_q.delete();
      model_ovf = 1'b0;
      model_unf = 1'b0;
    end else begin
      pop  = r && (model_q.size() > 0);
      push = w && ((model_q.size() < DP) || pop);
      if (r && model_q.size() == 0) model_unf = 1'b1;
      if (w && !push) model_ovf = 1'b1;
      if (pop) void'(model_q.pop_front());
      if (push) model_q.push_back(d);
    end
    write = 1'b0;
    read  = 1'b0;
    flush = 1'b0;
  endtask

  task automatic model_clear();
    model_q.delete();
    model_ovf = 1'b0;
    model_unf = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    cycle(1'b0, '0, 1'b0, 1'b0);
    total++;
    if ({empty, full, almost_full, overflow, underflow, level} !== {5'b10000, LW'(0)}) begin
      bad++;
      $display("[TB] FAIL reset_state: got e=%b f=%b af=%b ov=%b un=%b lvl=%0d want e=1 f=0 af=0 ov=0 un=0 lvl=0",
               empty, full, almost_full, overflow, underflow, level);
    end
  endtask

  task automatic test_single();
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    total++;
    if (empty !== 1'b0 || sample !== 8'hA5 || level !== LW'(1)) begin
      bad++;
      $display("[TB] FAIL single_write: got e=%b s=%h lvl=%0d want e=0 s=a5 lvl=1", empty, sample, level);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    total++;
    if (empty !== 1'b1 || level !== LW'(0)) begin
      bad++;
      $display("[TB] FAIL single_read: got e=%b lvl=%0d want e=1 lvl=0", empty, level);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < DP; i++) begin
      cycle(1'b1, DW'(i), 1'b0, 1'b0);
      total++;
      if (int'(level) !== i + 1 || almost_full !== (i + 1 >= AF) || full !== (i + 1 == DP)) begin
        bad++;
        $display("[TB] FAIL fill_flags: got lvl=%0d af=%b f=%b want lvl=%0d af=%b f=%b",
                 level, almost_full, full, i + 1, (i + 1 >= AF), (i + 1 == DP));
      end
    end
    cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    total++;
    if (overflow !== 1'b1 || level !== LW'(DP)) begin
      bad++;
      $display("[TB] FAIL overflow_write: got ov=%b lvl=%0d want ov=1 lvl=%0d", overflow, level, DP);
    end
    for (int i = 0; i < DP; i++) begin
      total++;
      if (sample !== DW'(i)) begin
        bad++;
        $display("[TB] FAIL drain_order: got %h want %h", sample, DW'(i));
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    total++;
    if (empty !== 1'b1 || level !== LW'(0)) begin
      bad++;
      $display("[TB] FAIL drain_empty: got e=%b lvl=%0d want e=1 lvl=0", empty, level);
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 8'h12, 1'b0, 1'b0);
    cycle(1'b1, 8'h34, 1'b0, 1'b0);
    total++;
    if (sample !== 8'h12 || level !== LW'(2)) begin
      bad++;
      $display("[TB] FAIL b2b_head: got s=%h lvl=%0d want s=12 lvl=2", sample, level);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    total++;
    if (sample !== 8'h34 || level !== LW'(1)) begin
      bad++;
      $display("[TB] FAIL b2b_second: got s=%h lvl=%0d want s=34 lvl=1", sample, level);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    total++;
    if (level !== LW'(0) || empty !== 1'b1 || underflow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL b2b_drained: got lvl=%0d e=%b un=%b want lvl=0 e=1 un=0", level, empty, underflow);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    total++;
    if (underflow !== 1'b1 || level !== LW'(0)) begin
      bad++;
      $display("[TB] FAIL underflow_read: got un=%b lvl=%0d want un=1 lvl=0", underflow, level);
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_full_read_write();
    logic [DW-1:0] exp;
    for (int i = 0; i < DP; i++) cycle(1'b1, DW'($urandom_range(0, 255)), 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    total++;
    if (level !== LW'(DP) || overflow !== 1'b0 || full !== 1'b1) begin
      bad++;
      $display("[TB] FAIL full_rw: got lvl=%0d ov=%b f=%b want lvl=%0d ov=0 f=1", level, overflow, full, DP);
    end
    while (model_q.size() > 0) begin
      exp = model_q[0];
      total++;
      if (sample !== exp) begin
        bad++;
        $display("[TB] FAIL full_rw_drain: got %h want %h", sample, exp);
      end
      if (model_q.size() == 1) begin
        total++;
        if (sample !== 8'h77) begin
          bad++;
          $display("[TB] FAIL full_rw_last: got %h want 77", sample);
        end
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i <= DP; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
    for (int i = 0; i < DP - 10; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    total++;
    if (level !== LW'(10) || overflow !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pre_flush: got lvl=%0d ov=%b want lvl=10 ov=1", level, overflow);
    end
    cycle(1'b1, 8'h5A, 1'b0, 1'b1);
    total++;
    if (level !== LW'(0) || empty !== 1'b1 || overflow !== 1'b0 || almost_full !== 1'b0) begin
      bad++;
      $display("[TB] FAIL flush: got lvl=%0d e=%b ov=%b af=%b want lvl=0 e=1 ov=0 af=0", level, empty, overflow, almost_full);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < AF + 2; i++) cycle(1'b1, DW'($urandom_range(0, 255)), 1'b0, 1'b0);
    cycle(1'b1, 8'h00, 1'b1, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if ({empty, full, almost_full, overflow, underflow, level} !== {5'b10000, LW'(0)}) begin
      bad++;
      $display("[TB] FAIL async_reset: got e=%b f=%b af=%b ov=%b un=%b lvl=%0d want e=1 f=0 af=0 ov=0 un=0 lvl=0",
               empty, full, almost_full, overflow, underflow, level);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_random();
    bit w;
    bit r;
    bit f;
    int wp;
    for (int n = 0; n < 3000; n++) begin
      wp = ((n / 250) % 2 == 0) ? 70 : 30;
      w  = ($urandom_range(0, 99) < wp);
      r  = ($urandom_range(0, 99) < 100 - wp);
      f  = ($urandom_range(0, 299) == 0);
      if (model_q.size() > 0) begin
        total++;
        if (sample !== model_q[0]) begin
          bad++;
          $display("[TB] FAIL rand_sample: got %h want %h", sample, model_q[0]);
        end
      end
      cycle(w, DW'($urandom_range(0, 255)), r, f);
      total++;
      if (int'(level) !== model_q.size() || empty !== (model_q.size() == 0) ||
          full !== (model_q.size() == DP) || almost_full !== (model_q.size() >= AF) ||
          overflow !== model_ovf || underflow !== model_unf) begin
        bad++;
        $display("[TB] FAIL rand_state: got lvl=%0d e=%b f=%b af=%b ov=%b un=%b want lvl=%0d ov=%b un=%b",
                 level, empty, full, almost_full, overflow, underflow, model_q.size(), model_ovf, model_unf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_back_to_back();
    test_full_read_write();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
